// File: rtl/sme_feeder_if.sv
// sme_feeder_if: upstream byte stream, matcher-facing byte stream and status.
// master = record source / matcher side, slave = sme_feeder.
interface sme_feeder_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_type;
  logic       in_last;
  logic       in_ready;
  logic       sme_valid;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       busy;
  logic       err;

  modport master (
    output in_valid, in_data, in_type, in_last, sme_valid,
    input  in_ready, chardata, isstring, ispattern, busy, err
  );

  modport slave (
    input  in_valid, in_data, in_type, in_last, sme_valid,
    output in_ready, chardata, isstring, ispattern, busy, err
  );
endinterface

// File: rtl/sme_feeder.sv
// sme_feeder: buffers string (32B) / pattern (8B) records, streams them to a matcher.
// Ports: clk, reset (async, active-low), bus (sme_feeder_if.slave).
// Option: `SME_FEEDER_TIMEOUT_EN makes WAIT give up after 100 cycles with err.
module sme_feeder (
  input  logic        clk,
  input  logic        reset,
  sme_feeder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND_S, SEND_P, WAIT
  } state_t;

  state_t     state, state_d;
  logic [7:0] str_buf [32];
  logic [7:0] pat_buf [8];
  logic [5:0] str_len, str_len_d;
  logic [3:0] pat_len, pat_len_d;
  logic       rec_type, rec_type_d;
  logic       ovf, ovf_d;
  logic       str_pend, str_pend_d;
  logic       str_seen, str_seen_d;
  logic [5:0] idx, idx_d;
  logic [7:0] cd, cd_d;
  logic       is_s, is_s_d;
  logic       is_p, is_p_d;
  logic       err_q, err_d;
`ifdef SME_FEEDER_TIMEOUT_EN
  logic [6:0] tmo, tmo_d;
`endif

  logic       xfer;
  logic       cur_type;
  logic       cur_ovf;
  logic [5:0] s_cur;
  logic [3:0] p_cur;
  logic [7:0] pat0;
  logic       str_we;
  logic       pat_we;

  assign bus.in_ready  = reset & ((state == IDLE) | (state == LOAD));
  assign bus.busy      = (state != IDLE);
  assign bus.chardata  = cd;
  assign bus.isstring  = is_s;
  assign bus.ispattern = is_p;
  assign bus.err       = err_q;

  assign xfer     = bus.in_valid & bus.in_ready;
  // First byte of a record restarts type, length and overflow tracking.
  assign cur_type = (state == IDLE) ? bus.in_type : rec_type;
  assign cur_ovf  = (state == IDLE) ? 1'b0 : ovf;
  assign s_cur    = (state == IDLE) ? 6'd0 : str_len;
  assign p_cur    = (state == IDLE) ? 4'd0 : pat_len;
  assign str_we   = xfer & ~cur_type & (s_cur < 6'd32);
  assign pat_we   = xfer & cur_type & (p_cur < 4'd8);
  // A 1-byte pattern is still being written when it is dispatched.
  assign pat0     = (state == IDLE) ? bus.in_data : pat_buf[0];

  always_ff @(posedge clk) begin
    if (str_we) str_buf[s_cur[4:0]] <= bus.in_data;
    if (pat_we) pat_buf[p_cur[2:0]] <= bus.in_data;
  end

  always_comb begin
    state_d    = state;
    str_len_d  = str_len;
    pat_len_d  = pat_len;
    rec_type_d = rec_type;
    ovf_d      = ovf;
    str_pend_d = str_pend;
    str_seen_d = str_seen;
    idx_d      = idx;
    cd_d       = 8'd0;
    is_s_d     = 1'b0;
    is_p_d     = 1'b0;
    err_d      = 1'b0;
`ifdef SME_FEEDER_TIMEOUT_EN
    tmo_d      = tmo;
`endif
    unique case (state)
      IDLE, LOAD: begin
        if (xfer) begin
          rec_type_d = cur_type;
          state_d    = LOAD;
          if (cur_type) begin
            ovf_d     = cur_ovf | (p_cur == 4'd8);
            pat_len_d = (p_cur == 4'd8) ? p_cur : p_cur + 4'd1;
          end else begin
            ovf_d     = cur_ovf | (s_cur == 6'd32);
            str_len_d = (s_cur == 6'd32) ? s_cur : s_cur + 6'd1;
          end
          if (bus.in_last) begin
            err_d   = ovf_d;
            state_d = IDLE;
            if (!cur_type) begin
              str_pend_d = 1'b1;
              str_seen_d = 1'b1;
            end else if (str_pend) begin
              state_d = SEND_S;
              cd_d    = str_buf[0];
              is_s_d  = 1'b1;
              idx_d   = 6'd1;
            end else if (str_seen) begin
              state_d = SEND_P;
              cd_d    = pat0;
              is_p_d  = 1'b1;
              idx_d   = 6'd1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      SEND_S: begin
        if (idx < str_len) begin
          cd_d   = str_buf[idx[4:0]];
          is_s_d = 1'b1;
          idx_d  = idx + 6'd1;
        end else begin
          state_d    = SEND_P;
          str_pend_d = 1'b0;
          cd_d       = pat_buf[0];
          is_p_d     = 1'b1;
          idx_d      = 6'd1;
        end
      end
      SEND_P: begin
        if (idx < {2'b00, pat_len}) begin
          cd_d   = pat_buf[idx[2:0]];
          is_p_d = 1'b1;
          idx_d  = idx + 6'd1;
        end else begin
          state_d = WAIT;
`ifdef SME_FEEDER_TIMEOUT_EN
          tmo_d   = 7'd0;
`endif
        end
      end
      WAIT: begin
        if (bus.sme_valid) begin
          state_d = IDLE;
`ifdef SME_FEEDER_TIMEOUT_EN
        end else if (tmo == 7'd99) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo + 7'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      str_len  <= 6'd0;
      pat_len  <= 4'd0;
      rec_type <= 1'b0;
      ovf      <= 1'b0;
      str_pend <= 1'b0;
      str_seen <= 1'b0;
      idx      <= 6'd0;
      cd       <= 8'd0;
      is_s     <= 1'b0;
      is_p     <= 1'b0;
      err_q    <= 1'b0;
`ifdef SME_FEEDER_TIMEOUT_EN
      tmo      <= 7'd0;
`endif
    end else begin
      state    <= state_d;
      str_len  <= str_len_d;
      pat_len  <= pat_len_d;
      rec_type <= rec_type_d;
      ovf      <= ovf_d;
      str_pend <= str_pend_d;
      str_seen <= str_seen_d;
      idx      <= idx_d;
      cd       <= cd_d;
      is_s     <= is_s_d;
      is_p     <= is_p_d;
      err_q    <= err_d;
`ifdef SME_FEEDER_TIMEOUT_EN
      tmo      <= tmo_d;
`endif
    end
  end

endmodule
